demux128_reg: RTL and testbench

DEMUX128_REG -- requirements
Module: demux128_reg

---
 rtl/demux128_reg_pkg.sv | 28 ++
 rtl/demux128_reg_if.sv | 46 ++++
 rtl/demux128_slot.sv | 68 ++++++
 rtl/demux128_reg.sv | 89 ++++++++
 tb/tb_demux128_reg.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/demux128_reg_pkg.sv
// ----------------------------------------------------------------------------
// demux128_reg_pkg
//   Shared definitions for the demux128_reg slice: default data width, default
//   per-destination counter width, the single-entry slot state encoding, the
//   destination encoding, and a small helper used for output steering.
// ----------------------------------------------------------------------------
package demux128_reg_pkg;

  localparam int DEF_WIDTH = 128;
  localparam int DEF_CNTW  = 8;

  // Occupancy of the single registered entry.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Destination encoding carried alongside the held word.
  localparam logic DST_A = 1'b0;
  localparam logic DST_B = 1'b1;

  // True when the held entry is valid and addressed to destination 'port'.
  function automatic logic slot_targets(input logic full, input logic dst,
                                        input logic port);
    return full && (dst == port);
  endfunction

endpackage : demux128_reg_pkg

// File: rtl/demux128_reg_if.sv
// ----------------------------------------------------------------------------
// demux128_reg_if
//   Bundles the source handshake, both destination handshakes and the two
//   delivery counters of demux128_reg.
//   master : the environment (drives in/in_valid/sel and both out*_ready)
//   slave  : the demux block (drives in_ready, outa/outb, valids, counters)
//   Data words are ordered [0:WIDTH-1]; bit 0 is the MSB.
// ----------------------------------------------------------------------------
interface demux128_reg_if
  import demux128_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
);

  // Source side
  logic [0:WIDTH-1] in;
  logic             in_valid;
  logic             sel;
  logic             in_ready;

  // Destination A
  logic [0:WIDTH-1] outa;
  logic             outa_valid;
  logic             outa_ready;

  // Destination B
  logic [0:WIDTH-1] outb;
  logic             outb_valid;
  logic             outb_ready;

  // Delivery counters
  logic [CNTW-1:0]  cnta;
  logic [CNTW-1:0]  cntb;

  modport master (
    output in, in_valid, sel, outa_ready, outb_ready,
    input  in_ready, outa, outa_valid, outb, outb_valid, cnta, cntb
  );

  modport slave (
    input  in, in_valid, sel, outa_ready, outb_ready,
    output in_ready, outa, outa_valid, outb, outb_valid, cnta, cntb
  );

endinterface : demux128_reg_if

// File: rtl/demux128_slot.sv
// ----------------------------------------------------------------------------
// demux128_slot
//   Single-entry holding register: data word, destination bit and full flag.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset (slot -> EMPTY, zeros)
//     load       : capture d/dst_in this edge; slot is FULL afterwards
//     clear      : held word has left this edge; slot empties unless load
//     d, dst_in  : incoming word and its destination
//     data_p0    : held word
//     dst_p0     : held destination (0 = A, 1 = B)
//     full       : entry valid
//   load wins over clear so a same-cycle drain and refill keeps the slot FULL.
// ----------------------------------------------------------------------------
module demux128_slot
  import demux128_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [0:WIDTH-1] d,
  input  logic             dst_in,
  output logic [0:WIDTH-1] data_p0,
  output logic             dst_p0,
  output logic             full
);

  state_t state, state_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (load) state_nxt = FULL;
      end
      FULL: begin
        if (load)       state_nxt = FULL;
        else if (clear) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Stage p0: the held word. Cleared on reset so a discarded word leaves no
  // trace on the outputs or in the register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_p0 <= '0;
      dst_p0  <= DST_A;
    end else if (load) begin
      data_p0 <= d;
      dst_p0  <= dst_in;
    end
  end

  assign full = (state == FULL);

endmodule : demux128_slot

// File: rtl/demux128_reg.sv
// ----------------------------------------------------------------------------
// demux128_reg
//   Registered 1-to-2 demultiplexer with valid/ready handshakes. One word is
//   held at a time and presented to the destination chosen by sel when it
//   was accepted; the other destination sees zeros. Per-destination counters
//   record delivered words and wrap silently.
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     reset : asynchronous active-high reset
//     bus   : demux128_reg_if.slave
//             in/in_valid/sel/in_ready        source handshake
//             outa/outa_valid/outa_ready      destination A
//             outb/outb_valid/outb_ready      destination B
//             cnta/cntb                       delivered-word counters
// ----------------------------------------------------------------------------
module demux128_reg
  import demux128_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic          clk,
  input  logic          reset,
  demux128_reg_if.slave bus
);

  logic [0:WIDTH-1] data_p0;
  logic             dst_p0;
  logic             full;

  logic             vld_a_p0;
  logic             vld_b_p0;
  logic             xfer_a;
  logic             xfer_b;
  logic             xfer_out;
  logic             load;

  logic [CNTW-1:0]  cnta_q;
  logic [CNTW-1:0]  cntb_q;

  demux128_slot #(
    .WIDTH (WIDTH)
  ) u_slot (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .clear   (xfer_out),
    .d       (bus.in),
    .dst_in  (bus.sel),
    .data_p0 (data_p0),
    .dst_p0  (dst_p0),
    .full    (full)
  );

  // Only the addressed destination's ready can complete a transfer; the
  // other ready is masked out by the valid term.
  assign vld_a_p0 = slot_targets(full, dst_p0, DST_A);
  assign vld_b_p0 = slot_targets(full, dst_p0, DST_B);
  assign xfer_a   = vld_a_p0 & bus.outa_ready;
  assign xfer_b   = vld_b_p0 & bus.outb_ready;
  assign xfer_out = xfer_a | xfer_b;

  // Ready while empty, or while the held word drains this same cycle so a
  // continuous stream runs at one word per clock. full is reset
  // asynchronously, so this rises immediately with reset.
  assign bus.in_ready = ~full | xfer_out;
  assign load         = bus.in_valid & bus.in_ready;

  // Stage p0 outputs: steer the held word, zeros elsewhere.
  assign bus.outa_valid = vld_a_p0;
  assign bus.outb_valid = vld_b_p0;
  assign bus.outa       = vld_a_p0 ? data_p0 : '0;
  assign bus.outb       = vld_b_p0 ? data_p0 : '0;

  // Delivery counters; natural modulo-2^CNTW wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnta_q <= '0;
      cntb_q <= '0;
    end else begin
      if (xfer_a) cnta_q <= cnta_q + 1'b1;
      if (xfer_b) cntb_q <= cntb_q + 1'b1;
    end
  end

  assign bus.cnta = cnta_q;
  assign bus.cntb = cntb_q;

endmodule : demux128_reg

// File: tb/tb_demux128_reg.sv
module tb_demux128_reg;

  localparam int WIDTH = 128;
  localparam int CNTW  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  demux128_reg_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  demux128_reg #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] w11, wv, ww, wr;

  initial begin
    w11 = {32{4'h1}};
    wv  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D;
    ww  = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;

    bus.in         = '0;
    bus.in_valid   = 1'b0;
    bus.sel        = 1'b0;
    bus.outa_ready = 1'b0;
    bus.outb_ready = 1'b0;

    // Reset state
    step();
    chk("rst_in_ready", 128'(bus.in_ready),   128'd1);
    chk("rst_outa_vld", 128'(bus.outa_valid), 128'd0);
    chk("rst_outb_vld", 128'(bus.outb_valid), 128'd0);
    chk("rst_outa",     bus.outa,             128'd0);
    chk("rst_cnta",     128'(bus.cnta),       128'd0);
    chk("rst_cntb",     128'(bus.cntb),       128'd0);
    reset = 1'b0;

    // Single word to A, accepted on the first edge after reset
    bus.in = w11; bus.sel = 1'b0; bus.in_valid = 1'b1; bus.outa_ready = 1'b1;
    #1;
    chk("a1_in_ready", 128'(bus.in_ready), 128'd1);
    step();
    chk("a1_outa_vld", 128'(bus.outa_valid), 128'd1);
    chk("a1_outa",     bus.outa,             w11);
    chk("a1_outb",     bus.outb,             128'd0);
    chk("a1_outb_vld", 128'(bus.outb_valid), 128'd0);
    bus.in_valid = 1'b0;
    step();
    chk("a1_empty", 128'(bus.outa_valid), 128'd0);
    chk("a1_cnta",  128'(bus.cnta),       128'd1);

    // Word to B stalled 5 cycles; A-ready high and a competing offer ignored
    bus.in = wv; bus.sel = 1'b1; bus.in_valid = 1'b1; bus.outb_ready = 1'b0;
    step();
    bus.in = ww; bus.sel = 1'b0; bus.outa_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("b_hold_vld",   128'(bus.outb_valid), 128'd1);
      chk("b_hold_rdy",   128'(bus.in_ready),   128'd0);
      chk("b_hold_data",  bus.outb,             wv);
      chk("b_hold_outa",  bus.outa,             128'd0);
      step();
    end
    bus.in_valid = 1'b0; bus.outb_ready = 1'b1;
    #1;
    chk("b_drain_rdy", 128'(bus.in_ready), 128'd1);
    step();
    chk("b_done_vld", 128'(bus.outb_valid), 128'd0);
    chk("b_cntb",     128'(bus.cntb),       128'd1);
    chk("b_cnta",     128'(bus.cnta),       128'd1);

    // Back-to-back 0,1,2,3 with alternating destination
    bus.outa_ready = 1'b1; bus.outb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in = 128'(i); bus.sel = i[0]; bus.in_valid = 1'b1;
      #1;
      chk("s_in_ready", 128'(bus.in_ready), 128'd1);
      step();
      if (i[0]) begin
        chk("s_outb", bus.outb, 128'(i));
        chk("s_outb_vld", 128'(bus.outb_valid), 128'd1);
      end else begin
        chk("s_outa", bus.outa, 128'(i));
        chk("s_outa_vld", 128'(bus.outa_valid), 128'd1);
      end
    end
    bus.in_valid = 1'b0;
    step();
    // One each from the earlier tests plus two each from the stream
    chk("s_cnta", 128'(bus.cnta), 128'd3);
    chk("s_cntb", 128'(bus.cntb), 128'd3);

    // Reset while FULL: asynchronous discard
    bus.in = ww; bus.sel = 1'b0; bus.in_valid = 1'b1; bus.outa_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk("r_full_vld", 128'(bus.outa_valid), 128'd1);
    chk("r_full_rdy", 128'(bus.in_ready),   128'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("r_async_vld",  128'(bus.outa_valid), 128'd0);
    chk("r_async_rdy",  128'(bus.in_ready),   128'd1);
    chk("r_async_outa", bus.outa,             128'd0);
    chk("r_async_cnta", 128'(bus.cnta),       128'd0);
    chk("r_async_cntb", 128'(bus.cntb),       128'd0);
    bus.outa_ready = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("r_never_vld",  128'(bus.outa_valid), 128'd0);
    chk("r_never_cnta", 128'(bus.cnta),       128'd0);

    // 256 words to A: counter wraps to 0
    bus.sel = 1'b0; bus.in_valid = 1'b1; bus.outb_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.in = 128'(i + 16);
      step();
    end
    chk("w_cnta_255", 128'(bus.cnta), 128'hff);
    bus.in_valid = 1'b0;
    step();
    chk("w_cnta_wrap", 128'(bus.cnta), 128'd0);
    chk("w_cntb_zero", 128'(bus.cntb), 128'd0);

    // in_valid low with noisy sel/in: nothing happens
    for (int i = 0; i < 12; i++) begin
      wr = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.in = wr; bus.sel = 1'($urandom_range(0, 1));
      step();
      chk("idle_outa_vld", 128'(bus.outa_valid), 128'd0);
      chk("idle_outb_vld", 128'(bus.outb_valid), 128'd0);
    end
    chk("idle_cnta", 128'(bus.cnta), 128'd0);
    chk("idle_cntb", 128'(bus.cntb), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_demux128_reg
